// File: rtl/s2p_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : s2p_rx_if
// Description : Bundle of the serial-to-parallel receiver's bus signals.
//               master : serial source / result consumer
//                        (drives ENB, frame_in, data_in)
//               slave  : the receiver (drives Q0..Q3, data_out, valid,
//                        sync_err, parity_err)
// Ports       : ENB        - bit enable; 0 stalls the receiver
//               frame_in   - marks the first bit of a frame
//               data_in    - four serial lanes, lane i carries byte i
//               Q0..Q3     - reassembled bytes of lanes 0..3
//               data_out   - {Q3,Q2,Q1,Q0}
//               valid      - one-cycle pulse when the outputs update
//               sync_err   - one-cycle pulse on a mid-frame restart
//               parity_err - per-lane parity error, qualified by valid
// Revision    : 1.0 - initial release
// ============================================================================
interface s2p_rx_if;
    logic        ENB;
    logic        frame_in;
    logic [3:0]  data_in;
    logic [7:0]  Q0;
    logic [7:0]  Q1;
    logic [7:0]  Q2;
    logic [7:0]  Q3;
    logic [31:0] data_out;
    logic        valid;
    logic        sync_err;
    logic [3:0]  parity_err;

    modport master (
        output ENB, frame_in, data_in,
        input  Q0, Q1, Q2, Q3, data_out, valid, sync_err, parity_err
    );

    modport slave (
        input  ENB, frame_in, data_in,
        output Q0, Q1, Q2, Q3, data_out, valid, sync_err, parity_err
    );
endinterface
`default_nettype wire

// File: rtl/s2p_rx.sv
`default_nettype none
// ============================================================================
// Module      : s2p_rx
// Description : Four-lane serial-to-parallel receiver. Each lane shifts one
//               bit per enabled clock into a private 8-bit register; at the
//               end of a frame the four bytes are loaded into registered
//               outputs and a one-cycle valid pulse is produced.
// Parameters  : MSB_FIRST - 1: lanes deliver bit 7 first, 0: bit 0 first
// Macro       : S2P_PARITY_EN - when defined, frames are 9 bits long and the
//               9th bit of each lane is even parity over its 8 data bits;
//               when undefined, frames are 8 bits and parity_err is 0.
// Ports       : clk   - serial bit clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - s2p_rx_if.slave (ENB, frame_in, data_in in;
//                       Q0..Q3, data_out, valid, sync_err, parity_err out)
// Revision    : 1.0 - initial release
// ============================================================================
module s2p_rx #(
    parameter int MSB_FIRST = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    s2p_rx_if.slave    bus
);

`ifdef S2P_PARITY_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;        // index of the next bit to be sampled
    logic [7:0]  sr_q [4];
    logic [7:0]  q_q  [4];
    logic        valid_q;
    logic        sync_err_q;

    logic [7:0]  w_shift [4];  // lane register with the current bit shifted in
    logic [7:0]  w_byte  [4];  // byte delivered when the frame completes
    logic        w_last;

`ifdef S2P_PARITY_EN
    logic [3:0]  perr_q;
    logic [3:0]  w_perr;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_lane
        if (MSB_FIRST != 0) begin : g_msb
            assign w_shift[i] = {sr_q[i][6:0], bus.data_in[i]};
        end else begin : g_lsb
            assign w_shift[i] = {bus.data_in[i], sr_q[i][7:1]};
        end
`ifdef S2P_PARITY_EN
        // The last bit is parity, so the data byte is already complete.
        assign w_byte[i] = sr_q[i];
        assign w_perr[i] = (^sr_q[i]) ^ bus.data_in[i];
`else
        // The last data bit is still on the lane; deliver it directly.
        assign w_byte[i] = w_shift[i];
`endif
    end

    assign w_last = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sr_q[i] <= 8'd0;
                q_q[i]  <= 8'd0;
            end
`ifdef S2P_PARITY_EN
            perr_q     <= 4'd0;
`endif
        end else begin
            // Status outputs are single-cycle pulses, also while stalled.
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
`ifdef S2P_PARITY_EN
            perr_q     <= 4'd0;
`endif
            if (bus.ENB) begin
                case (state_q)
                    IDLE: begin
                        if (bus.frame_in) begin
                            state_q <= SHIFT;
                            cnt_q   <= 4'd1;
                            for (int i = 0; i < 4; i++) sr_q[i] <= w_shift[i];
                        end
                    end
                    SHIFT: begin
                        if (w_last) begin
                            for (int i = 0; i < 4; i++) q_q[i] <= w_byte[i];
                            valid_q <= 1'b1;
`ifdef S2P_PARITY_EN
                            perr_q  <= w_perr;
`endif
                            // frame_in on the last bit also opens the next
                            // frame; this lane value doubles as its bit 0.
                            if (bus.frame_in) begin
                                cnt_q <= 4'd1;
                                for (int i = 0; i < 4; i++) sr_q[i] <= w_shift[i];
                            end else begin
                                state_q <= IDLE;
                                cnt_q   <= 4'd0;
                            end
                        end else if (bus.frame_in) begin
                            // Restart: the partial frame is dropped and this
                            // bit becomes bit 0; stale bits shift out.
                            cnt_q      <= 4'd1;
                            sync_err_q <= 1'b1;
                            for (int i = 0; i < 4; i++) sr_q[i] <= w_shift[i];
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            for (int i = 0; i < 4; i++) sr_q[i] <= w_shift[i];
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign bus.Q0       = q_q[0];
    assign bus.Q1       = q_q[1];
    assign bus.Q2       = q_q[2];
    assign bus.Q3       = q_q[3];
    assign bus.data_out = {q_q[3], q_q[2], q_q[1], q_q[0]};
    assign bus.valid    = valid_q;
    assign bus.sync_err = sync_err_q;
`ifdef S2P_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_s2p_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_s2p_rx
// Description : Self-checking bench for s2p_rx. Stimulus tasks push the
//               expected word, parity flags and completion edge into a
//               scoreboard; a negedge monitor pops and compares whenever
//               valid or sync_err is seen.
// Macro       : S2P_PARITY_EN - selects 9-bit frames and the parity test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s2p_rx;
    localparam int MSB_FIRST = 1;
`ifdef S2P_PARITY_EN
    localparam int N = 9;
`else
    localparam int N = 8;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    s2p_rx_if bus ();

    s2p_rx #(.MSB_FIRST(MSB_FIRST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  perr;
        int          edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   sync_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Drive one clock worth of inputs; returns 1 ns after the sampling edge.
    task automatic step(input logic en, input logic fr, input logic [3:0] d);
        bus.ENB      = en;
        bus.frame_in = fr;
        bus.data_in  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] lane_bits(input logic [31:0] w, input int k, input logic [3:0] inj);
        logic [3:0] r;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            if (k < 8) r[i] = (MSB_FIRST != 0) ? b[7-k] : b[k];
            else       r[i] = (^b) ^ inj[i];
        end
        return r;
    endfunction

    // Send nbits of a frame; stall_n ENB-low cycles (with frame_in high,
    // which must be ignored) are inserted after bit stall_after.
    task automatic send_frame(input logic [31:0] w, input int nbits, input int stall_after,
                              input int stall_n, input logic [3:0] inj, input logic exp_sync);
        int start = 0;
        exp_t e;
        for (int k = 0; k < nbits; k++) begin
            step(1'b1, k == 0, lane_bits(w, k, inj));
            if (k == 0) begin
                start = cyc;
                if (exp_sync) sync_q.push_back(cyc);
            end
            if (k == stall_after) begin
                repeat (stall_n) step(1'b0, 1'b1, 4'hF);
            end
        end
        if (nbits == N) begin
            e.word   = w;
`ifdef S2P_PARITY_EN
            e.perr   = inj;
`else
            e.perr   = 4'd0;
`endif
            e.edge_n = start + (N - 1) + ((stall_after >= 0 && stall_after < N - 1) ? stall_n : 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 4'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   s;
        if (bus.valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 data_out=%h expected no valid (cycle %0d)",
                         bus.data_out, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", bus.data_out, e.word);
                chk("Q0", {24'd0, bus.Q0}, {24'd0, e.word[7:0]});
                chk("Q1", {24'd0, bus.Q1}, {24'd0, e.word[15:8]});
                chk("Q2", {24'd0, bus.Q2}, {24'd0, e.word[23:16]});
                chk("Q3", {24'd0, bus.Q3}, {24'd0, e.word[31:24]});
                chk("parity_err", {28'd0, bus.parity_err}, {28'd0, e.perr});
                chk("valid_cycle", 32'(cyc), 32'(e.edge_n));
            end
        end
        if (bus.sync_err) begin
            if (sync_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sync_err: got sync_err=1 expected 0 (cycle %0d)", cyc);
            end else begin
                s = sync_q.pop_front();
                chk("sync_err_cycle", 32'(cyc), 32'(s));
            end
        end
    end

    initial begin
        bus.ENB      = 1'b0;
        bus.frame_in = 1'b0;
        bus.data_in  = 4'h0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", bus.data_out, 32'h0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_sync_err", {31'd0, bus.sync_err}, 32'd0);
        chk("rst_parity_err", {28'd0, bus.parity_err}, 32'd0);
        rst_n = 1'b1;

        // Idle noise: frame_in with ENB low, data with no frame_in.
        step(1'b0, 1'b1, 4'hA);
        step(1'b0, 1'b1, 4'h5);
        step(1'b1, 1'b0, 4'hF);
        step(1'b1, 1'b0, 4'h3);

        send_frame(32'h44332211, N, -1, 0, 4'd0, 1'b0);
        idle(2);

        // Back-to-back frames, second frame_in one cycle after last bit.
        send_frame(32'hA5A5A5A5, N, -1, 0, 4'd0, 1'b0);
        send_frame(32'h5A5A5A5A, N, -1, 0, 4'd0, 1'b0);
        idle(2);

        // Three-cycle stall after bit 3.
        send_frame(32'hDEADBEEF, N, 3, 3, 4'd0, 1'b0);
        idle(2);

        // Abort at bit 5, then a full frame.
        send_frame(32'h77777777, 5, -1, 0, 4'd0, 1'b0);
        send_frame(32'h01020304, N, -1, 0, 4'd0, 1'b1);
        idle(2);

        // Reset during bit 4 of a frame.
        send_frame(32'h12345678, 4, -1, 0, 4'd0, 1'b0);
        bus.ENB      = 1'b1;
        bus.frame_in = 1'b0;
        bus.data_in  = lane_bits(32'h12345678, 4, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data_out", bus.data_out, 32'h0);
        chk("mid_rst_Q0", {24'd0, bus.Q0}, 32'h0);
        chk("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        send_frame(32'hCAFEF00D, N, -1, 0, 4'd0, 1'b0);
        idle(2);

        send_frame(32'h80C0E0F1, N, -1, 0, 4'd0, 1'b0);
        idle(2);

`ifdef S2P_PARITY_EN
        send_frame(32'h0F0F0F0F, N, -1, 0, 4'b0100, 1'b0);
        idle(2);
`endif

        idle(3);
        chk("pending_valid", 32'(exp_q.size()), 32'd0);
        chk("pending_sync_err", 32'(sync_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/s2p_rx.md
S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 Parameter MSB_FIRST, default 1; 1 = each lane delivers bit 7 first, 0 = bit 0 first.
REQ-002 CLK  input  1  serial bit clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ENB  input  1  bit enable; 0 = hold all state (stall), no bit consumed.
REQ-005 frame_in  input  1  high on the cycle carrying the first bit of a frame.
REQ-006 data_in  input  4  serial lanes; lane i carries byte i.
REQ-007 Q0, Q1, Q2, Q3  output  8 each  reassembled bytes of lanes 0..3, registered.
REQ-008 data_out  output  32  {Q3,Q2,Q1,Q0}, registered.
REQ-009 valid  output  1  one-cycle pulse when Q0..Q3/data_out are updated.
REQ-010 sync_err  output  1  one-cycle pulse on frame restart mid-frame.
REQ-011 parity_err  output  4  per-lane parity error, valid with valid (S2P_PARITY_EN only; else tied 0).

Function
REQ-012 FSM states: IDLE, SHIFT; IDLE->SHIFT on ENB&frame_in; SHIFT->IDLE after last bit with no new frame_in.
REQ-013 Frame length N = 8 bits (9 with S2P_PARITY_EN); 3/4-bit bit counter, cleared on frame_in.
REQ-014 Bit k of a frame is sampled on the k-th ENB-qualified edge, k=0 on the frame_in cycle.
REQ-015 Each lane shifts into a private 8-bit shift register; order per MSB_FIRST.
REQ-016 On the edge sampling the last data/parity bit: Q0..Q3, data_out load, valid=1 on the following cycle (latency 1 cycle after last bit).
REQ-017 Q0..Q3/data_out hold value between frames; only updated on frame completion.
REQ-018 frame_in on the cycle after the last bit: back-to-back frame, no idle cycle, no sync_err.
REQ-019 frame_in in SHIFT before the last bit: discard partial frame, restart count at bit 0, sync_err=1 next cycle, no valid.
REQ-020 frame_in together with last bit of current frame: complete current frame (valid) and start new one.
REQ-021 ENB=0: counter, shift registers, FSM frozen; valid/sync_err deassert (pulses not stretched); frame_in ignored.
REQ-022 frame_in in IDLE with ENB=0 ignored; data_in ignored in IDLE without frame_in.

Reset
REQ-023 reset=0 asynchronously forces: FSM=IDLE, counter=0, shift regs=0, Q0..Q3=0, data_out=0, valid=0, sync_err=0, parity_err=0.
REQ-024 Reset mid-frame discards the partial frame; no valid pulse follows release.
REQ-025 After reset release, first frame_in with ENB=1 starts a frame on that edge.

Configuration
REQ-026 Macro S2P_PARITY_EN defined: 9-bit frames, 9th bit per lane is even parity over that lane's 8 data bits; parity_err[i]=1 with valid if mismatch; data still delivered.
REQ-027 Macro S2P_PARITY_EN undefined: 8-bit frames, no parity logic, parity_err constant 0.

Verification
REQ-028 Reset, MSB_FIRST=1, ENB=1, send 0x11,0x22,0x33,0x44 on lanes 0..3 -> valid one cycle after bit 7, data_out=0x44332211.
REQ-029 Two back-to-back frames 0xA5A5A5A5 then 0x5A5A5A5A, frame_in on cycle after last bit -> two valid pulses N cycles apart, correct words, sync_err=0.
REQ-030 ENB low for 3 cycles mid-frame (after bit 3) sending 0xDEADBEEF -> valid delayed exactly 3 cycles, data_out=0xDEADBEEF.
REQ-031 frame_in reasserted at bit 5, then full frame 0x01020304 -> sync_err pulse, no valid for aborted frame, data_out=0x01020304.
REQ-032 reset asserted at bit 4 of a frame -> all outputs 0 immediately, no valid after release; next full frame 0xCAFEF00D decoded.
REQ-033 S2P_PARITY_EN defined, lane 2 parity bit inverted on frame 0x0F0F0F0F -> valid, data_out=0x0F0F0F0F, parity_err=4'b0100.
